sr_bank_arbiter: RTL
====================

SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the flag bank.
REQ-002 Parameter NFLAG, default 8, number of SR flag bits in the bank.
REQ-003 Parameter IW, default 3, flag index width; SHALL satisfy 2**IW >= NFLAG.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NREQ  per-requester request, held high until that requester's gnt is seen.
REQ-007 op_s  input  NREQ  per-requester set bit, held stable while req is high.
REQ-008 op_r  input  NREQ  per-requester reset bit, held stable while req is high.
REQ-009 idx  input  NREQ*IW  per-requester target flag index, packed so requester k uses bits [k*IW +: IW], held stable while req is high.
REQ-010 clr_all  input  1  synchronous clear of every flag.
REQ-011 gnt  output  NREQ  registered, one-hot or zero, one-cycle grant pulse.
REQ-012 err  output  1  registered, one-cycle pulse for an illegal or out-of-range op.
REQ-013 q  output  NFLAG  registered flag bank.
REQ-014 qb  output  NFLAG  registered complement of q.

Function
REQ-015 Arbitration SHALL run every cycle over the eligible set, which is req with the currently high gnt bit masked out.
REQ-016 Arbitration SHALL be round-robin: search starts at requester (last_winner+1) mod NREQ and takes the first eligible requester.
REQ-017 At edge E with a non-empty eligible set: gnt SHALL take the winner's one-hot value; last_winner SHALL update; the winner's {op_s, op_r, idx} SHALL be captured into a pending register with pend_valid=1.
REQ-018 At edge E with an empty eligible set: gnt SHALL go to 0 and pend_valid SHALL go to 0.
REQ-019 Grant throughput: at most one grant per cycle; back-to-back grants to different requesters SHALL be allowed.
REQ-020 A pending op SHALL be applied at edge E+1, one cycle after its gnt rises; q SHALL change at E+1 and not earlier.
REQ-021 Apply, selected by {s,r}: 00 hold; 01 q[idx]=0; 10 q[idx]=1; 11 no change to q, err=1.
REQ-022 idx >= NFLAG: no change to q, err=1.
REQ-023 err SHALL be 0 in every cycle that does not follow an edge at which an error op was applied.
REQ-024 Bits of q other than q[idx] SHALL remain unchanged by an apply.
REQ-025 qb SHALL equal ~q in every cycle, including after reset.
REQ-026 clr_all at an edge SHALL set q=0, qb=all ones, and discard the pending op applied at that edge, with err=0.
REQ-027 clr_all SHALL NOT affect arbitration, gnt, or a new capture at the same edge.
REQ-028 A requester deasserting req before its grant SHALL lose the request silently.
REQ-029 A requester granted at E that keeps req high SHALL be masked during the gnt cycle and eligible again from cycle E+1 onward.

Reset
REQ-030 With rst high at an edge: q=0, qb=all ones, gnt=0, err=0, pend_valid=0, last_winner=NREQ-1, so requester 0 has top priority first.
REQ-031 rst SHALL override clr_all and any pending or incoming op at the same edge.
REQ-032 rst mid-operation SHALL discard the pending op; no apply and no err for it after reset releases.

Verification
REQ-033 Reset, then req=0001, op_s=1, op_r=0, idx0=5 -> gnt=0001 one cycle after req; q=0x20, qb=0xDF one cycle after gnt; err=0.
REQ-034 req=1111 held and re-raised continuously from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; no requester granted twice in consecutive cycles.
REQ-035 Requester 2 issues op s=1, r=1, idx=3 with q=0x08 -> q stays 0x08 and err pulses exactly one cycle, one cycle after gnt=0100.
REQ-036 Requester 1 issues op s=1, idx=7 (NFLAG=4, IW=3) -> no q change, err=1 for one cycle.
REQ-037 Pending set of idx 2 with clr_all high at its apply edge -> q=0, err=0; a new capture at that edge still occurs and applies next cycle.
REQ-038 rst asserted in the gnt cycle of a set op -> q stays 0 after rst releases; gnt=0; next req=0010 is granted by requester priority 0-first order.

Source files
------------

// File: rtl/sr_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_arbiter
// Description : Round-robin arbiter granting NREQ requesters set/reset access
//               to a shared bank of SR flags; ops apply one cycle after grant.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op_s,
  input  logic [NREQ-1:0]      op_r,
  input  logic [NREQ*IW-1:0]   idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic [NFLAG-1:0]     q,
  output logic [NFLAG-1:0]     qb
);

  localparam int              LW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW-1:0]   C_LAST_RST = LW'(NREQ - 1);

  logic [NREQ-1:0]  r_gnt;
  logic             r_err;
  logic [NFLAG-1:0] r_q;
  logic [NFLAG-1:0] r_qb;
  logic [LW-1:0]    r_last;
  logic             r_pend_valid;
  logic             r_pend_s;
  logic             r_pend_r;
  logic [IW-1:0]    r_pend_idx;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [LW-1:0]    w_win;
  logic [LW-1:0]    w_cand;
  logic             w_idx_ok;
  logic [NFLAG-1:0] w_q_next;
  logic             w_err_next;

  // The requester currently holding its grant pulse sits out this round.
  assign w_elig = req & ~r_gnt;

  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = LW'((int'(r_last) + k + 1) % NREQ);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_idx_ok = (32'(r_pend_idx) < 32'(NFLAG));

  // clr_all wins over whatever op is being applied at the same edge.
  always_comb begin
    w_q_next   = r_q;
    w_err_next = 1'b0;
    if (r_pend_valid) begin
      if ((r_pend_s && r_pend_r) || !w_idx_ok) begin
        w_err_next = 1'b1;
      end else begin
        for (int i = 0; i < NFLAG; i++) begin
          if (32'(r_pend_idx) == 32'(i)) begin
            if (r_pend_s) begin
              w_q_next[i] = 1'b1;
            end else if (r_pend_r) begin
              w_q_next[i] = 1'b0;
            end
          end
        end
      end
    end
    if (clr_all) begin
      w_q_next   = '0;
      w_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= '0;
      r_err        <= 1'b0;
      r_q          <= '0;
      r_qb         <= '1;
      r_last       <= C_LAST_RST;
      r_pend_valid <= 1'b0;
      r_pend_s     <= 1'b0;
      r_pend_r     <= 1'b0;
      r_pend_idx   <= '0;
    end else begin
      r_q   <= w_q_next;
      r_qb  <= ~w_q_next;
      r_err <= w_err_next;
      if (w_found) begin
        r_gnt        <= NREQ'(1) << w_win;
        r_last       <= w_win;
        r_pend_valid <= 1'b1;
        r_pend_s     <= op_s[w_win];
        r_pend_r     <= op_r[w_win];
        r_pend_idx   <= idx[int'(w_win)*IW +: IW];
      end else begin
        r_gnt        <= '0;
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign gnt = r_gnt;
  assign err = r_err;
  assign q   = r_q;
  assign qb  = r_qb;

endmodule
`default_nettype wire
